// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter / return-address stack.
package pc_pkg;

  // Default program address width
  localparam int PC_ADDR_W = 8;

  // Top-level sequencing state: RUN is normal, FAULT is absorbing until reset
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  // Decoded command for this cycle, after priority resolution
  typedef enum logic [1:0] {
    CMD_INC  = 2'd0,
    CMD_JUMP = 2'd1,
    CMD_CALL = 2'd2,
    CMD_RET  = 2'd3
  } cmd_t;

  // Priority encoder: call beats return beats jump beats plain increment
  function automatic cmd_t decode_cmd(input logic call, input logic ret, input logic jump);
    cmd_t cmd;
    if (call) begin
      cmd = CMD_CALL;
    end else if (ret) begin
      cmd = CMD_RET;
    end else if (jump) begin
      cmd = CMD_JUMP;
    end else begin
      cmd = CMD_INC;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/lifo_stack.sv
// Fixed-depth LIFO of return addresses. Popped slots are cleared so that no
// stale address is ever observable. Push and pop are assumed pre-qualified by
// the owner, but over/underflow is still blocked locally.
module lifo_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_ADDR_W,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [WIDTH-1:0] top_s;

  // Occupancy flags and qualified push/pop (push wins if both arrive)
  always_comb begin
    full_s    = (count_r == CNT_W'(DEPTH));
    empty_s   = (count_r == {CNT_W{1'b0}});
    push_ok_s = push && !full_s;
    pop_ok_s  = pop && !empty_s && !push;
  end

  // Top-of-stack selection; reads zero when the stack is empty
  always_comb begin
    top_s = {WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (count_r == CNT_W'(i + 1)) begin
        top_s = mem_r[i];
      end else begin
        top_s = top_s;
      end
    end
  end

  // Entry storage: write on push at the free slot, clear the slot on pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok_s && (count_r == CNT_W'(i))) begin
          mem_r[i] <= din;
        end else if (pop_ok_s && (count_r == CNT_W'(i + 1))) begin
          mem_r[i] <= {WIDTH{1'b0}};
        end else begin
          mem_r[i] <= mem_r[i];
        end
      end
    end
  end

  // Occupancy counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (push_ok_s) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (pop_ok_s) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign top   = top_s;
  assign count = count_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with hardware return-address stack. Handles increment,
// jump, call and return; any stack overflow/underflow parks the block in a
// sticky FAULT state where everything is frozen until reset.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int              ADDR_W      = PC_ADDR_W,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = {ADDR_W{1'b0}},
  localparam int             DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               i_Timming,
  input  logic               i_Rst,
  input  logic               i_Enable,
  input  logic               i_Jump,
  input  logic               i_Call,
  input  logic               i_Ret,
  input  logic [ADDR_W-1:0]  i_Target,
  output logic [ADDR_W-1:0]  o_Fetch,
  output logic [ADDR_W-1:0]  o_Stack,
  output logic [DEPTH_W-1:0] o_Depth,
  output logic               o_Full,
  output logic               o_Empty,
  output logic               o_Fault
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  state_t             state_nxt_s;
  logic [ADDR_W-1:0]  pc_r;
  logic [ADDR_W-1:0]  pc_nxt_s;
  logic [ADDR_W-1:0]  ret_addr_s;
  cmd_t               cmd_s;
  logic               push_s;
  logic               pop_s;
  logic [ADDR_W-1:0]  stk_top_s;
  logic [DEPTH_W-1:0] stk_count_s;
  logic               stk_full_s;
  logic               stk_empty_s;

  lifo_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (i_Timming),
    .rst   (i_Rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (ret_addr_s),
    .top   (stk_top_s),
    .count (stk_count_s),
    .full  (stk_full_s),
    .empty (stk_empty_s)
  );

  // Command decode and next-state / next-PC logic
  always_comb begin
    cmd_s       = decode_cmd(i_Call, i_Ret, i_Jump);
    ret_addr_s  = pc_r + PC_ONE;
    pc_nxt_s    = pc_r;
    state_nxt_s = state_r;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (i_Enable) begin
          case (cmd_s)
            CMD_CALL: begin
              if (stk_full_s) begin
                state_nxt_s = ST_FAULT;
              end else begin
                push_s   = 1'b1;
                pc_nxt_s = i_Target;
              end
            end
            CMD_RET: begin
              if (stk_empty_s) begin
                state_nxt_s = ST_FAULT;
              end else begin
                pop_s    = 1'b1;
                pc_nxt_s = stk_top_s;
              end
            end
            CMD_JUMP: begin
              pc_nxt_s = i_Target;
            end
            CMD_INC: begin
              pc_nxt_s = pc_r + PC_ONE;
            end
            default: begin
              state_nxt_s = ST_FAULT;
            end
          endcase
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      ST_FAULT: begin
        state_nxt_s = ST_FAULT;
      end
      default: begin
        state_nxt_s = ST_FAULT;
      end
    endcase
  end

  // State and PC registers
  always_ff @(posedge i_Timming or posedge i_Rst) begin
    if (i_Rst) begin
      state_r <= ST_RUN;
      pc_r    <= RESET_ADDR;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

  assign o_Fetch = pc_r;
  assign o_Stack = stk_top_s;
  assign o_Depth = stk_count_s;
  assign o_Full  = stk_full_s;
  assign o_Empty = stk_empty_s;
  assign o_Fault = (state_r == ST_FAULT);

endmodule

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack: each driven cycle runs a behavioural
// model, queues the expected outputs, and the queue is drained after the edge.
module tb_pc_call_stack;

  logic       i_Timming = 1'b0;
  logic       i_Rst     = 1'b1;
  logic       i_Enable  = 1'b0;
  logic       i_Jump    = 1'b0;
  logic       i_Call    = 1'b0;
  logic       i_Ret     = 1'b0;
  logic [7:0] i_Target  = 8'h00;
  logic [7:0] o_Fetch;
  logic [7:0] o_Stack;
  logic [2:0] o_Depth;
  logic       o_Full;
  logic       o_Empty;
  logic       o_Fault;

  pc_call_stack #(
    .ADDR_W      (8),
    .STACK_DEPTH (4),
    .RESET_ADDR  (8'h00)
  ) dut (
    .i_Timming (i_Timming),
    .i_Rst     (i_Rst),
    .i_Enable  (i_Enable),
    .i_Jump    (i_Jump),
    .i_Call    (i_Call),
    .i_Ret     (i_Ret),
    .i_Target  (i_Target),
    .o_Fetch   (o_Fetch),
    .o_Stack   (o_Stack),
    .o_Depth   (o_Depth),
    .o_Full    (o_Full),
    .o_Empty   (o_Empty),
    .o_Fault   (o_Fault)
  );

  always #5 i_Timming = ~i_Timming;

  typedef struct packed {
    logic [7:0] fetch;
    logic [7:0] stk;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       fault;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // reference model state
  logic [7:0] m_pc;
  logic [7:0] m_stk [4];
  int         m_depth;
  logic       m_fault;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 8'h00;
    m_depth = 0;
    m_fault = 1'b0;
    for (int i = 0; i < 4; i++) m_stk[i] = 8'h00;
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.fetch = m_pc;
    e.stk   = (m_depth > 0) ? m_stk[m_depth-1] : 8'h00;
    e.depth = 3'(m_depth);
    e.full  = (m_depth == 4);
    e.empty = (m_depth == 0);
    e.fault = m_fault;
    return e;
  endfunction

  task automatic model_step(input logic en, input logic c, input logic r, input logic j,
                            input logic [7:0] tgt);
    if (en && !m_fault) begin
      if (c) begin
        if (m_depth == 4) m_fault = 1'b1;
        else begin
          m_stk[m_depth] = m_pc + 8'h01;
          m_depth++;
          m_pc = tgt;
        end
      end else if (r) begin
        if (m_depth == 0) m_fault = 1'b1;
        else begin
          m_depth--;
          m_pc = m_stk[m_depth];
          m_stk[m_depth] = 8'h00;
        end
      end else if (j) begin
        m_pc = tgt;
      end else begin
        m_pc = m_pc + 8'h01;
      end
    end
  endtask

  task automatic compare_outputs(input string tag, input exp_t e);
    check_eq({tag, ".fetch"}, 32'(o_Fetch), 32'(e.fetch));
    check_eq({tag, ".stack"}, 32'(o_Stack), 32'(e.stk));
    check_eq({tag, ".depth"}, 32'(o_Depth), 32'(e.depth));
    check_eq({tag, ".full"},  32'(o_Full),  32'(e.full));
    check_eq({tag, ".empty"}, 32'(o_Empty), 32'(e.empty));
    check_eq({tag, ".fault"}, 32'(o_Fault), 32'(e.fault));
  endtask

  // drive one cycle (called at posedge+1), queue expectation, check after edge
  task automatic cycle(input string tag, input logic en, input logic c, input logic r,
                       input logic j, input logic [7:0] tgt);
    exp_t e;
    i_Enable = en; i_Call = c; i_Ret = r; i_Jump = j; i_Target = tgt;
    model_step(en, c, r, j, tgt);
    sb_q.push_back(model_view());
    @(posedge i_Timming);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      compare_outputs(tag, e);
    end
  endtask

  // mid-cycle async reset; outputs must be at reset values before any edge
  task automatic pulse_reset(input string tag);
    i_Enable = 1'b0; i_Call = 1'b0; i_Ret = 1'b0; i_Jump = 1'b0;
    #2;
    i_Rst = 1'b1;
    #1;
    model_reset();
    compare_outputs({tag, ".rst"}, model_view());
    check_eq({tag, ".rst_fetch0"}, 32'(o_Fetch), 32'h0);
    #2;
    i_Rst = 1'b0;
    @(posedge i_Timming);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    compare_outputs("por", model_view());
    #5;
    i_Rst = 1'b0;
    @(posedge i_Timming);
    #1;

    // plain increments 1..5
    for (int k = 0; k < 5; k++) cycle("inc", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check_eq("inc.pc5", 32'(o_Fetch), 32'h05);
    pulse_reset("mid");

    // call from 0x10 to 0x80, two increments, return to 0x11
    cycle("j10", 1'b1, 1'b0, 1'b0, 1'b1, 8'h10);
    cycle("call80", 1'b1, 1'b1, 1'b0, 1'b0, 8'h80);
    check_eq("call80.stack11", 32'(o_Stack), 32'h11);
    cycle("inc81", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle("inc82", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle("ret", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("ret.fetch11", 32'(o_Fetch), 32'h11);

    // nested calls to full, then overflow
    pulse_reset("nest");
    cycle("c20", 1'b1, 1'b1, 1'b0, 1'b0, 8'h20);
    cycle("c40", 1'b1, 1'b1, 1'b0, 1'b0, 8'h40);
    cycle("c60", 1'b1, 1'b1, 1'b0, 1'b0, 8'h60);
    cycle("c70", 1'b1, 1'b1, 1'b0, 1'b0, 8'h70);
    check_eq("c70.full", 32'(o_Full), 32'h1);
    cycle("c90", 1'b1, 1'b1, 1'b0, 1'b0, 8'h90);
    check_eq("ovf.fault", 32'(o_Fault), 32'h1);
    check_eq("ovf.fetch70", 32'(o_Fetch), 32'h70);
    cycle("ovf.jmp", 1'b1, 1'b0, 1'b0, 1'b1, 8'h33);
    cycle("ovf.ret", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    cycle("ovf.inc", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    pulse_reset("ovf");
    cycle("ovf.after", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // underflow
    pulse_reset("udf");
    cycle("j05", 1'b1, 1'b0, 1'b0, 1'b1, 8'h05);
    cycle("udf.ret", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("udf.fault", 32'(o_Fault), 32'h1);
    for (int k = 0; k < 3; k++) cycle("udf.hold", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check_eq("udf.fetch05", 32'(o_Fetch), 32'h05);

    // wrap
    pulse_reset("wrap");
    cycle("jff", 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
    cycle("wrap.inc", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check_eq("wrap.fetch00", 32'(o_Fetch), 32'h00);
    cycle("jff2", 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
    cycle("wrap.call", 1'b1, 1'b1, 1'b0, 1'b0, 8'h40);
    check_eq("wrap.push00", 32'(o_Stack), 32'h00);
    cycle("wrap.ret", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

    // simultaneous commands, then stall
    pulse_reset("prio");
    cycle("p.j10", 1'b1, 1'b0, 1'b0, 1'b1, 8'h10);
    cycle("p.c30", 1'b1, 1'b1, 1'b0, 1'b0, 8'h30);
    cycle("p.all", 1'b1, 1'b1, 1'b1, 1'b1, 8'h50);
    check_eq("prio.fetch50", 32'(o_Fetch), 32'h50);
    check_eq("prio.depth2", 32'(o_Depth), 32'h2);
    for (int k = 0; k < 3; k++) cycle("stall", 1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
    check_eq("stall.fetch50", 32'(o_Fetch), 32'h50);
    cycle("p.rj", 1'b1, 1'b0, 1'b1, 1'b1, 8'h77);
    check_eq("prio.ret_over_jump", 32'(o_Fetch), 32'h31);

    // stalled return on empty stack never faults
    pulse_reset("sret");
    cycle("stall.ret", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("stall.nofault", 32'(o_Fault), 32'h0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      if (m_fault && ($urandom_range(0, 3) == 0)) pulse_reset("rnd");
      cycle("rnd", ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
Parametrised program counter with a hardware return-address stack for call/return sequencing.
- Advances the fetch address once per enabled clock.
- Executes jumps, calls (push return address, then branch) and returns (pop, then branch back).
- Drives the instruction-memory fetch address and exposes stack status to the control unit.
- Freezes in a fault state on stack overflow or underflow until reset.

Parameters:
ADDR_W, 8, width of program address and stack entries
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_ADDR, 0, fetch address loaded on reset
DEPTH_W, $clog2(STACK_DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
i_Timming  in  1  system clock, rising edge
i_Rst  in  1  asynchronous active-high reset
i_Enable  in  1  advance/execute this cycle; 0 = stall, all state held
i_Jump  in  1  load PC with i_Target, stack untouched
i_Call  in  1  push return address, load PC with i_Target
i_Ret  in  1  pop top of stack into PC
i_Target  in  ADDR_W  jump/call destination
o_Fetch  out  ADDR_W  current fetch address (registered PC)
o_Stack  out  ADDR_W  top-of-stack entry; 0 when empty
o_Depth  out  DEPTH_W  number of valid stack entries
o_Full  out  1  o_Depth == STACK_DEPTH
o_Empty  out  1  o_Depth == 0
o_Fault  out  1  sticky overflow/underflow indicator

Behaviour:
- Reset (async, immediate): PC=RESET_ADDR, depth=0, all stack entries=0, state=RUN, o_Fault=0. Every output reaches its reset value without a clock edge.
- All updates occur on the rising edge of i_Timming, only when i_Enable=1 and state=RUN. Outputs are registered and take effect the cycle after the command.
- Command priority when several are asserted: i_Call > i_Ret > i_Jump > increment. Lower-priority commands are ignored.
- Increment: PC <= PC+1, modulo 2^ADDR_W. From all-ones it wraps to 0.
- Jump: PC <= i_Target.
- Call, stack not full:
  - stack[depth] <= PC+1 (wrapping);
  - depth <= depth+1;
  - PC <= i_Target.
- Call, stack full: no push, PC held, state <= FAULT.
- Ret, stack not empty:
  - PC <= stack[depth-1];
  - depth <= depth-1;
  - the popped slot is cleared to 0.
- Ret, stack empty: PC held, state <= FAULT.
- State machine:
  - RUN: normal operation.
  - FAULT: absorbing. PC, stack and depth are frozen; o_Fault=1; all commands ignored. Only i_Rst exits to RUN.
- o_Stack = stack[depth-1] when depth>0, else 0. o_Full, o_Empty and o_Depth are consistent every cycle.
- i_Enable=0 stalls regardless of commands; a stall never sets the fault.
- Call and return in the same cycle: the call wins, and i_Ret is not deferred.
- Reset mid-operation (any state, any depth) restores reset values immediately; no residual stack contents are visible afterwards.

Decomposition:
- Shared package pc_pkg:
  - state enum {ST_RUN, ST_FAULT};
  - command enum {CMD_INC, CMD_JUMP, CMD_CALL, CMD_RET}, produced by the priority encoder;
  - default width constant PC_ADDR_W=8.
- One sub-module: lifo_stack, parametrised (WIDTH, DEPTH), with push/pop/full/empty/top/count and the same clock/reset. pc_call_stack holds the PC register, the priority decode and the FSM.

Test Plan:
- Reset then 5 enabled cycles, no commands -> o_Fetch 0,1,2,3,4,5; o_Empty=1; o_Stack=0; pulse i_Rst mid-clock -> o_Fetch=0 immediately.
- PC=0x10, i_Call with i_Target=0x80 -> next cycle o_Fetch=0x80, o_Stack=0x11, o_Depth=1; increment twice, then i_Ret -> o_Fetch=0x11, o_Empty=1.
- STACK_DEPTH=4: nested calls from 0x00 to 0x20, 0x40, 0x60, 0x70 -> o_Full=1, o_Depth=4; fifth call to 0x90 -> o_Fault=1, o_Fetch stays 0x70; further commands ignored until i_Rst.
- Empty stack, i_Ret at PC=0x05 -> o_Fault=1, o_Fetch holds 0x05 on all later edges.
- PC=0xFF, increment -> 0x00; i_Call at PC=0xFF -> pushed return address 0x00.
- PC=0x30, depth 1 (top 0x11), i_Call+i_Ret+i_Jump together with i_Target=0x50 -> call taken: o_Fetch=0x50, o_Depth=2; then i_Enable=0 with i_Jump=1 for 3 cycles -> o_Fetch stays 0x50.
